// File: rtl/adc_scan_ctrl.sv
// Scanning controller for an ALE/START/EOC/OE style 8-channel ADC with a free-running adc_clk.
// Define ADC_SCAN_TIMEOUT_EN to add a conversion watchdog that drives err_timeout.
module adc_scan_ctrl #(
  parameter int CLK_DIV     = 27,
  parameter int ALE_CYC     = 4,
  parameter int START_CYC   = 8,
  parameter int OE_CYC      = 12,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [7:0] ch_mask,
  input  logic       eoc,
  input  logic [7:0] adc_input,
  input  logic       res_ready,
  output logic       adc_clk,
  output logic       ale,
  output logic       start,
  output logic       oe,
  output logic [2:0] addr,
  output logic [7:0] res_data,
  output logic [2:0] res_ch,
  output logic       res_valid,
  output logic       busy,
  output logic       err_timeout,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ALE, S_START, S_WAIT_LOW, S_WAIT_HIGH, S_OE, S_OUTPUT
  } state_t;

  localparam int DW     = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int MAX_AS = (ALE_CYC > START_CYC) ? ALE_CYC : START_CYC;
  localparam int MAX_C  = (MAX_AS > OE_CYC) ? MAX_AS : OE_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_div;
  logic          r_adc_clk;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_cur_ch;
  logic [2:0]    r_last_ch;
  logic [7:0]    r_res_data;
  logic [2:0]    r_res_ch;
  logic [2:0]    w_sel_ch;
  logic          w_more;
  logic          w_timeout;
  logic          w_waiting;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div     <= '0;
      r_adc_clk <= 1'b0;
    end else if (r_div == DW'(CLK_DIV)) begin
      r_div     <= '0;
      r_adc_clk <= ~r_adc_clk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Scan from last_ch+1 upward with wrap; the lowest offset wins, so iterate downward.
  always_comb begin
    w_sel_ch = r_last_ch;
    for (int i = 8; i >= 1; i--) begin
      if (ch_mask[r_last_ch + 3'(i)]) w_sel_ch = r_last_ch + 3'(i);
    end
  end

  assign w_more    = scan_en && (ch_mask != 8'h00);
  assign w_waiting = (r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH);

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] r_wd_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err    <= w_timeout;
      r_wd_cnt <= (w_waiting && !w_timeout) ? r_wd_cnt + 1'b1 : '0;
    end
  end

  assign w_timeout   = w_waiting && (r_wd_cnt == WW'(TIMEOUT_CYC - 1));
  assign err_timeout = r_err;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_more) w_state_nxt = S_SELECT;
      S_SELECT:    w_state_nxt = S_ALE;
      S_ALE:       if (r_cnt == CW'(ALE_CYC - 1)) w_state_nxt = S_START;
      S_START:     if (r_cnt == CW'(START_CYC - 1)) w_state_nxt = S_WAIT_LOW;
      S_WAIT_LOW:  if (!eoc) w_state_nxt = S_WAIT_HIGH;
      S_WAIT_HIGH: if (eoc) w_state_nxt = S_OE;
      S_OE:        if (r_cnt == CW'(OE_CYC - 1)) w_state_nxt = S_OUTPUT;
      S_OUTPUT:    if (res_ready) w_state_nxt = w_more ? S_SELECT : S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    // Watchdog expiry overrides whatever eoc is doing this cycle.
    if (w_timeout) w_state_nxt = w_more ? S_SELECT : S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_ch   <= 3'd0;
      r_last_ch  <= 3'd7;
      r_res_data <= 8'h00;
      r_res_ch   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if ((r_state == S_ALE) || (r_state == S_START) || (r_state == S_OE)) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_SELECT) r_cur_ch <= w_sel_ch;
      if ((r_state == S_OE) && (w_state_nxt == S_OUTPUT)) begin
        r_res_data <= adc_input;
        r_res_ch   <= r_cur_ch;
        r_last_ch  <= r_cur_ch;
      end
      if (w_timeout) r_last_ch <= r_cur_ch;
    end
  end

  assign adc_clk     = r_adc_clk;
  assign ale         = (r_state == S_ALE);
  assign start       = (r_state == S_START);
  assign oe          = (r_state == S_OE);
  assign addr        = (r_state == S_SELECT) ? w_sel_ch : r_cur_ch;
  assign res_data    = r_res_data;
  assign res_ch      = r_res_ch;
  assign res_valid   = (r_state == S_OUTPUT);
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: behavioural converter model, pulse monitor and result scoreboard.
module tb_adc_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic [7:0] ch_mask;
  logic       eoc = 1'b1;
  logic [7:0] adc_input = 8'h00;
  logic       res_ready;
  logic       adc_clk, ale, start, oe, res_valid, busy, err_timeout;
  logic [2:0] addr, res_ch, dbg_state;
  logic [7:0] res_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  bit eoc_stuck = 1'b0;
  int conv_n = 0;

  // monitor state
  int cyc = 0, last_rise = 0, adc_per = 0;
  bit adc_d = 1'b0, per_done = 1'b0;
  int ale_run = 0, start_run = 0, oe_run = 0;
  int ale_w = 0, start_w = 0, oe_w = 0;
  int ale_pulses = 0, start_pulses = 0, width_bad = 0, overlap = 0, xfer_cnt = 0;

  adc_scan_ctrl dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .ch_mask(ch_mask), .eoc(eoc),
    .adc_input(adc_input), .res_ready(res_ready), .adc_clk(adc_clk), .ale(ale),
    .start(start), .oe(oe), .addr(addr), .res_data(res_data), .res_ch(res_ch),
    .res_valid(res_valid), .busy(busy), .err_timeout(err_timeout), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Converter: eoc falls 10 cycles after start rises, returns high 50 cycles later with new data.
  initial begin
    forever begin
      @(posedge start);
      if (!eoc_stuck) begin
        repeat (10) @(negedge clk);
        eoc = 1'b0;
        repeat (50) @(negedge clk);
        adc_input = 8'h3C + 8'(conv_n * 23);
        conv_n++;
        exp_q.push_back(adc_input);
        eoc = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    cyc++;
    if (adc_clk && !adc_d) begin
      if (last_rise > 0 && !per_done) begin
        adc_per  = cyc - last_rise;
        per_done = 1'b1;
      end
      last_rise = cyc;
    end
    adc_d = adc_clk;
    if (ale) ale_run++;
    else if (ale_run != 0) begin ale_w = ale_run; if (ale_run != 4) width_bad++; ale_run = 0; ale_pulses++; end
    if (start) start_run++;
    else if (start_run != 0) begin start_w = start_run; if (start_run != 8) width_bad++; start_run = 0; start_pulses++; end
    if (oe) oe_run++;
    else if (oe_run != 0) begin oe_w = oe_run; if (oe_run != 12) width_bad++; oe_run = 0; end
    if ((int'(ale) + int'(start) + int'(oe)) > 1) overlap++;
    if (res_valid && res_ready) xfer_cnt++;
  end

  task automatic get_result(input string tag, input logic [2:0] exp_ch);
    int n;
    logic [7:0] exp_d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (res_valid !== 1'b1 && n < 400);
    if (res_valid !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      check({tag, "_ch"}, 32'(res_ch), 32'(exp_ch));
      if (exp_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
      else begin
        exp_d = exp_q.pop_front();
        check({tag, "_data"}, 32'(res_data), 32'(exp_d));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_strobes"}, {29'd0, ale, start, oe}, 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_res"}, {20'd0, res_valid, res_ch, res_data}, 32'd0);
    check({tag, "_err"}, 32'(err_timeout), 32'd0);
    check({tag, "_adc_clk"}, 32'(adc_clk), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [2:0] exp_ch [4];
    logic [7:0] d0;
    int snap_ale, snap_start, snap_xfer, bad, n, rv_seen;
    bit ok;

    exp_ch = '{3'd0, 3'd2, 3'd0, 3'd2};
    reset = 1'b0; scan_en = 1'b0; ch_mask = 8'h00; res_ready = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (5) @(negedge clk);
    reset = 1'b1;

    // Enabled but empty mask stays idle.
    scan_en = 1'b1;
    repeat (20) @(negedge clk);
    check("mask0_idle", 32'(busy), 32'd0);

    // Round-robin over channels 0 and 2.
    ch_mask = 8'h05;
    for (int i = 0; i < 4; i++) get_result($sformatf("scan%0d", i), exp_ch[i]);
    check("ale_width", 32'(ale_w), 32'd4);
    check("start_width", 32'(start_w), 32'd8);
    check("oe_width", 32'(oe_w), 32'd12);
    check("adc_clk_period", 32'(adc_per), 32'd56);
    check("strobe_overlap", 32'(overlap), 32'd0);

    // Back-pressure: result must hold and no new conversion may start.
    @(negedge clk);
    res_ready = 1'b0;
    get_result("stall", 3'd0);
    d0 = res_data;
    snap_ale = ale_pulses; snap_start = start_pulses; snap_xfer = xfer_cnt;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== d0 || res_ch !== 3'd0) bad++;
    end
    check("stall_stable", 32'(bad), 32'd0);
    check("stall_no_ale", 32'(ale_pulses - snap_ale), 32'd0);
    check("stall_no_start", 32'(start_pulses - snap_start), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 32'(res_valid), 32'd0);
    check("stall_one_xfer", 32'(xfer_cnt - snap_xfer), 32'd1);

    // Drop scan_en during START: one last result, then idle.
    n = 0;
    while (start !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("wait_start", 32'(start), 32'd1);
    scan_en = 1'b0;
    get_result("drop", 3'd2);
    @(negedge clk);
    check("drop_busy", 32'(busy), 32'd0);
    snap_ale = ale_pulses;
    repeat (150) @(negedge clk);
    check("drop_no_rescan", 32'(ale_pulses - snap_ale), 32'd0);

    // Reset during WAIT_HIGH, then single-channel repeat on channel 7.
    ch_mask = 8'h80;
    scan_en = 1'b1;
    n = 0;
    while (dbg_state !== 3'd5 && n < 300) begin @(negedge clk); n++; end
    check("wait_high_reached", 32'(dbg_state), 32'd5);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    n = 0;
    while (eoc !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    get_result("ch7_a", 3'd7);
    get_result("ch7_b", 3'd7);
    scan_en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check("ch7_idle", 32'(busy), 32'd0);

    // Stuck eoc.
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    eoc_stuck = 1'b1;
    ch_mask = 8'h05;
    reset = 1'b1;
    scan_en = 1'b1;
    n = 0;
    while (dbg_state !== 3'd4 && n < 100) begin @(negedge clk); n++; end
    check("wait_low_reached", 32'(dbg_state), 32'd4);
    rv_seen = 0;
`ifdef ADC_SCAN_TIMEOUT_EN
    n = 0;
    ok = 1'b0;
    while (!ok && n < 1100) begin
      @(negedge clk);
      n++;
      if (res_valid) rv_seen++;
      if (err_timeout === 1'b1) ok = 1'b1;
    end
    check("timeout_latency", 32'(n), 32'd1000);
    check("timeout_state", 32'(dbg_state), 32'd1);
    check("timeout_next_addr", 32'(addr), 32'd2);
    @(negedge clk);
    check("timeout_pulse_width", 32'(err_timeout), 32'd0);
    scan_en = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 1200) begin
      @(negedge clk);
      n++;
      if (res_valid) rv_seen++;
    end
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_no_result", 32'(rv_seen), 32'd0);
`else
    ok = 1'b1;
    n = 0;
    repeat (1200) begin
      @(negedge clk);
      if (err_timeout !== 1'b0) n++;
      if (res_valid) rv_seen++;
    end
    check("no_wd_err", 32'(n), 32'd0);
    check("no_wd_still_waiting", 32'(dbg_state), 32'd4);
    check("no_wd_no_result", 32'(rv_seen), 32'd0);
`endif
    check("strobe_widths_all", 32'(width_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 27, adc_clk half-period minus one, in clk cycles.
REQ-002 SHALL have parameter ALE_CYC, default 4, ale high time in clk cycles.
REQ-003 SHALL have parameter START_CYC, default 8, start high time in clk cycles.
REQ-004 SHALL have parameter OE_CYC, default 12, oe high time before capture, in clk cycles.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000, conversion watchdog limit in clk cycles.
REQ-006 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-007 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have: scan_en  in  1  enables channel scanning.
REQ-009 SHALL have: ch_mask  in  8  enabled ADC channels, bit n = channel n.
REQ-010 SHALL have: eoc  in  1  converter end-of-conversion.
REQ-011 SHALL have: adc_input  in  8  converter data bus.
REQ-012 SHALL have: res_ready  in  1  downstream accepts result.
REQ-013 SHALL have: adc_clk, ale, start, oe  out  1 each  converter controls.
REQ-014 SHALL have: addr  out  3  converter channel address.
REQ-015 SHALL have: res_data  out  8, res_ch  out  3, res_valid  out  1  result channel.
REQ-016 SHALL have: busy  out  1, err_timeout  out  1  status.

Function
REQ-017 adc_clk SHALL toggle once every CLK_DIV+1 clk cycles, free-running, independent of the FSM.
REQ-018 FSM states SHALL be IDLE, SELECT, ALE, START, WAIT_LOW, WAIT_HIGH, OE, OUTPUT.
REQ-019 IDLE -> SELECT when scan_en=1 and ch_mask!=0; otherwise remain in IDLE.
REQ-020 SELECT SHALL pick the lowest set ch_mask bit above last_ch, wrapping past 7 to 0, latch it as cur_ch, and drive addr=cur_ch; -> ALE next cycle; ch_mask is sampled only here.
REQ-021 ALE: ale=1 for ALE_CYC cycles, addr held; -> START.
REQ-022 START: start=1 for START_CYC cycles, ale=0; -> WAIT_LOW.
REQ-023 WAIT_LOW -> WAIT_HIGH on eoc=0; WAIT_HIGH -> OE on eoc=1.
REQ-024 OE: oe=1 for OE_CYC cycles; on the last cycle, latch adc_input into res_data and cur_ch into res_ch, set last_ch=cur_ch; -> OUTPUT.
REQ-025 OUTPUT: res_valid=1, res_data/res_ch stable until a cycle with res_ready=1; that cycle ends the transfer; -> SELECT if scan_en=1 and ch_mask!=0, else IDLE.
REQ-026 res_ready while res_valid=0 SHALL be ignored.
REQ-027 scan_en dropping mid-conversion SHALL NOT abort; the current result is delivered, then -> IDLE.
REQ-028 Single-bit mask SHALL reconvert the same channel repeatedly; mask 8'h00 at OUTPUT exit -> IDLE.
REQ-029 busy=1 in every state except IDLE.
REQ-030 ale, start, oe SHALL be 0 in every state other than their own.

Reset
REQ-031 On reset=0, immediately: state=IDLE, adc_clk=0, ale=0, start=0, oe=0, addr=0, res_data=0, res_ch=0, res_valid=0, busy=0, err_timeout=0, last_ch=7, all counters 0.
REQ-032 Reset mid-conversion SHALL discard the conversion; after release the first scan starts at the lowest set bit of ch_mask.

Configuration
REQ-033 With ADC_SCAN_TIMEOUT_EN defined: a counter runs over WAIT_LOW plus WAIT_HIGH; at TIMEOUT_CYC cycles, err_timeout pulses high for exactly one cycle, last_ch=cur_ch, no result is produced, and the FSM goes to SELECT (or IDLE per REQ-025 conditions).
REQ-034 Without ADC_SCAN_TIMEOUT_EN: no watchdog logic, err_timeout tied 0, and the FSM waits indefinitely for eoc.

Verification
REQ-035 mask=8'h05, scan_en=1, model eoc low 10 cycles after start and high 50 cycles later, res_ready=1 -> results ch0,ch2,ch0,ch2 in order, res_data matches adc_input.
REQ-036 Hold res_ready=0 for 200 cycles in OUTPUT -> res_valid and res_data stay constant, no new ale/start pulses; res_ready=1 -> exactly one transfer.
REQ-037 Pulse/width check -> ale high 4 cycles, start high 8, oe high 12; adc_clk period 56 clk cycles.
REQ-038 With macro, eoc stuck at 1 -> err_timeout one-cycle pulse 1000 cycles after WAIT_LOW entry, no res_valid, next channel selected.
REQ-039 Assert reset during WAIT_HIGH with mask=8'h80 -> all outputs at reset values at once; after release, channel 7 is converted.
REQ-040 Drop scan_en during START -> the conversion completes, one result is delivered, then busy=0.
